rvga_mem_arbiter: RTL and testbench
===================================

// Module: rvga_mem_arbiter
// PURPOSE
//  Shares one memory port between instruction fetch (IF) and data memory (DM) requesters.
//  Data has fixed priority, with a starvation guard so fetch is always served eventually.
//  At most one transaction is outstanding; the response is routed back to the requester that owns it.
//  Sits between the fetch/mem stages and the memory model; its completions feed writeback.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width; wmask is DATA_W/8 bits
//  STARVE_LIMIT  4   consecutive DM grants with IF waiting before IF is forced; >=1
// PORTS
//  clk_i            in   1         clock; all logic on posedge
//  reset_i          in   1         synchronous, active-high reset
//  if_req_v_i       in   1         fetch request valid
//  if_req_addr_i    in   ADDR_W    fetch address
//  if_req_ready_o   out  1         fetch request accepted this cycle (1-cycle pulse)
//  if_kill_i        in   1         pipeline redirect; drop pending/new fetch
//  if_resp_v_o      out  1         fetch data valid (1-cycle pulse)
//  if_resp_data_o   out  DATA_W    fetch data
//  dm_req_v_i       in   1         data request valid
//  dm_req_addr_i    in   ADDR_W    data address
//  dm_req_we_i      in   1         1=store, 0=load
//  dm_req_wmask_i   in   DATA_W/8  byte write mask
//  dm_req_wdata_i   in   DATA_W    store data
//  dm_req_ready_o   out  1         data request accepted this cycle (1-cycle pulse)
//  dm_resp_v_o      out  1         load data / store ack valid (1-cycle pulse)
//  dm_resp_data_o   out  DATA_W    load data (store ack: memory's returned data, don't-care)
//  mem_req_v_o      out  1         memory request valid
//  mem_req_addr_o   out  ADDR_W    memory address
//  mem_req_we_o     out  1         memory write enable
//  mem_req_wmask_o  out  DATA_W/8  memory byte mask
//  mem_req_wdata_o  out  DATA_W    memory write data
//  mem_req_ready_i  in   1         memory accepts request
//  mem_resp_v_i     in   1         memory response valid (one per accepted request, loads and stores)
//  mem_resp_data_i  in   DATA_W    memory response data
//  busy_o           out  1         state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, starve_cnt=0, kill flag=0; all *_v_o, *_ready_o and busy_o are 0; data/addr regs are 0.
//  FSM IDLE -> REQ -> RESP -> IDLE.
//   IDLE: IF is eligible only when if_req_v_i & !if_kill_i.
//     Winner rules:
//       - DM wins if valid, unless IF is eligible and starve_cnt==STARVE_LIMIT.
//       - Otherwise IF wins if eligible.
//     Acceptance: the winner's ready_o pulses this cycle, the request fields and owner are latched,
//     and the FSM goes to REQ. The loser sees no ready and must hold its request.
//   REQ: mem_req_v_o=1 with latched fields, held stable until mem_req_ready_i; then go to RESP.
//   RESP: wait for mem_resp_v_i. Register data into owner's resp_data_o.
//     Pulse owner's resp_v_o on the next cycle (IF pulse suppressed if killed); go to IDLE.
//  Starvation counter:
//   - DM grant while if_req_v_i=1: starve_cnt++ (saturates at STARVE_LIMIT).
//   - IF grant, or DM grant with if_req_v_i=0: starve_cnt=0.
//  Latency:
//   - accept(c0) -> mem_req_v_o from c1.
//   - mem ready at c1 -> RESP from c2.
//   - mem_resp_v_i at cN -> resp_v_o at cN+1; earliest is c3.
//   - Next accept is possible the same cycle resp_v_o pulses (FSM is already back in IDLE).
//  Kill:
//   - if_kill_i while owner=IF in REQ/RESP sets the kill flag.
//   - The memory request is NOT retracted, and the response is still consumed.
//   - if_resp_v_o is suppressed for that response; the flag clears on return to IDLE.
//   - if_kill_i during a DM transaction has no effect.
//  mem_resp_v_i outside RESP is ignored (sim-only assertion fires).
//   Stale responses after reset are therefore dropped.
//  Reset mid-transaction abandons it; no resp_v_o pulse is produced for it.
//  if_resp_v_o and dm_resp_v_o are never high in the same cycle; ready_o pulses are mutually exclusive.
// TESTING
//  1. Reset, IF only @0x100; mem ready c1, resp c2 data 0x00000013.
//     -> if_req_ready_o@c0, if_resp_v_o@c3 data 0x13.
//  2. IF+DM load @0x200 both valid c0 -> DM granted first, IF ready only after DM completes;
//     starve_cnt=1.
//  3. IF held valid + DM continuously valid, STARVE_LIMIT=4
//     -> DM grants 1..4, 5th grant goes to IF, starve_cnt back to 0.
//  4. IF granted; if_kill_i at REQ cycle; mem resp later
//     -> no if_resp_v_o, busy_o drops, next DM request accepted normally.
//  5. DM store wmask 4'b0011 data 0xDEADBEEF, mem_req_ready_i low 5 cycles
//     -> fields held stable on mem_req_*_o, dm_resp_v_o 1 cycle after ack.
//  6. reset_i asserted in RESP, then stray mem_resp_v_i
//     -> outputs 0, no resp pulse, FSM stays IDLE.

Source files
------------

// File: rtl/rvga_mem_arbiter.sv
// Shares one memory port between instruction fetch and data requesters, one transaction at a time.
// Data has fixed priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module rvga_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                if_req_v_i,
    input  logic [ADDR_W-1:0]   if_req_addr_i,
    output logic                if_req_ready_o,
    input  logic                if_kill_i,
    output logic                if_resp_v_o,
    output logic [DATA_W-1:0]   if_resp_data_o,
    input  logic                dm_req_v_i,
    input  logic [ADDR_W-1:0]   dm_req_addr_i,
    input  logic                dm_req_we_i,
    input  logic [DATA_W/8-1:0] dm_req_wmask_i,
    input  logic [DATA_W-1:0]   dm_req_wdata_i,
    output logic                dm_req_ready_o,
    output logic                dm_resp_v_o,
    output logic [DATA_W-1:0]   dm_resp_data_o,
    output logic                mem_req_v_o,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic                mem_req_we_o,
    output logic [DATA_W/8-1:0] mem_req_wmask_o,
    output logic [DATA_W-1:0]   mem_req_wdata_o,
    input  logic                mem_req_ready_i,
    input  logic                mem_resp_v_i,
    input  logic [DATA_W-1:0]   mem_resp_data_i,
    output logic                busy_o
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state, state_next;
    logic              owner_dm;
    logic              kill_flag;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [MASK_W-1:0] req_wmask;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] if_data;
    logic [DATA_W-1:0] dm_data;
    logic              if_pulse;
    logic              dm_pulse;
    logic              if_eligible;
    logic              grant_dm;
    logic              grant_if;
    logic              mem_accept;
    logic              resp_take;

    // Grants are only issued from IDLE and never while reset is held, so ready stays low in reset.
    always_comb begin
        if_eligible = if_req_v_i & ~if_kill_i;
        grant_dm    = 1'b0;
        grant_if    = 1'b0;
        if (state == IDLE && !reset_i) begin
            if (dm_req_v_i && !(if_eligible && starve_cnt == CNT_MAX)) begin
                grant_dm = 1'b1;
            end else if (if_eligible) begin
                grant_if = 1'b1;
            end
        end
        mem_accept = (state == REQ) && mem_req_ready_i;
        resp_take  = (state == RESP) && mem_resp_v_i;
        state_next = state;
        case (state)
            IDLE:    if (grant_dm || grant_if) state_next = REQ;
            REQ:     if (mem_accept) state_next = RESP;
            RESP:    if (resp_take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            owner_dm   <= 1'b0;
            kill_flag  <= 1'b0;
            starve_cnt <= '0;
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_wmask  <= '0;
            req_wdata  <= '0;
            if_data    <= '0;
            dm_data    <= '0;
            if_pulse   <= 1'b0;
            dm_pulse   <= 1'b0;
        end else begin
            state    <= state_next;
            if_pulse <= resp_take && !owner_dm && !kill_flag && !if_kill_i;
            dm_pulse <= resp_take && owner_dm;
            if (grant_dm) begin
                owner_dm  <= 1'b1;
                req_addr  <= dm_req_addr_i;
                req_we    <= dm_req_we_i;
                req_wmask <= dm_req_wmask_i;
                req_wdata <= dm_req_wdata_i;
                if (!if_req_v_i) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else if (grant_if) begin
                owner_dm   <= 1'b0;
                req_addr   <= if_req_addr_i;
                req_we     <= 1'b0;
                req_wmask  <= '0;
                req_wdata  <= '0;
                starve_cnt <= '0;
            end
            // A killed fetch still completes on the memory side; only its response pulse is dropped.
            if (state != IDLE && !owner_dm && if_kill_i) begin
                kill_flag <= 1'b1;
            end
            if (resp_take) begin
                kill_flag <= 1'b0;
                if (owner_dm) begin
                    dm_data <= mem_resp_data_i;
                end else begin
                    if_data <= mem_resp_data_i;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Responses outside RESP are legal only for a request that reset abandoned after memory took it.
    logic mem_outstanding;
    always_ff @(posedge clk_i) begin
        if (mem_accept && !reset_i) begin
            mem_outstanding <= 1'b1;
        end else if (mem_resp_v_i) begin
            mem_outstanding <= 1'b0;
        end
        if (!reset_i && mem_resp_v_i) begin
            assert (state == RESP || mem_outstanding);
        end
    end
`endif

    assign if_req_ready_o  = grant_if;
    assign dm_req_ready_o  = grant_dm;
    assign mem_req_v_o     = (state == REQ);
    assign mem_req_addr_o  = req_addr;
    assign mem_req_we_o    = req_we;
    assign mem_req_wmask_o = req_wmask;
    assign mem_req_wdata_o = req_wdata;
    assign if_resp_v_o     = if_pulse;
    assign if_resp_data_o  = if_data;
    assign dm_resp_v_o     = dm_pulse;
    assign dm_resp_data_o  = dm_data;
    assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Self-checking bench for rvga_mem_arbiter: arbitration table, directed latency/kill/stall/reset
// sequences, and randomized traffic against a transaction-level reference model.
module tb_rvga_mem_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        if_req_v_i;
    logic [31:0] if_req_addr_i;
    logic        if_req_ready_o;
    logic        if_kill_i;
    logic        if_resp_v_o;
    logic [31:0] if_resp_data_o;
    logic        dm_req_v_i;
    logic [31:0] dm_req_addr_i;
    logic        dm_req_we_i;
    logic [3:0]  dm_req_wmask_i;
    logic [31:0] dm_req_wdata_i;
    logic        dm_req_ready_o;
    logic        dm_resp_v_o;
    logic [31:0] dm_resp_data_o;
    logic        mem_req_v_o;
    logic [31:0] mem_req_addr_o;
    logic        mem_req_we_o;
    logic [3:0]  mem_req_wmask_o;
    logic [31:0] mem_req_wdata_o;
    logic        mem_req_ready_i;
    logic        mem_resp_v_i;
    logic [31:0] mem_resp_data_i;
    logic        busy_o;

    always #5 clk = ~clk;

    rvga_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .if_req_v_i(if_req_v_i), .if_req_addr_i(if_req_addr_i), .if_req_ready_o(if_req_ready_o),
        .if_kill_i(if_kill_i), .if_resp_v_o(if_resp_v_o), .if_resp_data_o(if_resp_data_o),
        .dm_req_v_i(dm_req_v_i), .dm_req_addr_i(dm_req_addr_i), .dm_req_we_i(dm_req_we_i),
        .dm_req_wmask_i(dm_req_wmask_i), .dm_req_wdata_i(dm_req_wdata_i),
        .dm_req_ready_o(dm_req_ready_o), .dm_resp_v_o(dm_resp_v_o), .dm_resp_data_o(dm_resp_data_o),
        .mem_req_v_o(mem_req_v_o), .mem_req_addr_o(mem_req_addr_o), .mem_req_we_o(mem_req_we_o),
        .mem_req_wmask_o(mem_req_wmask_o), .mem_req_wdata_o(mem_req_wdata_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_resp_v_i(mem_resp_v_i),
        .mem_resp_data_i(mem_resp_data_i), .busy_o(busy_o)
    );

    typedef struct {
        logic        rst;
        logic        ifv;
        logic [31:0] ifa;
        logic        kill;
        logic        dmv;
        logic [31:0] dma;
        logic        we;
        logic [3:0]  wm;
        logic [31:0] wd;
        logic        mrdy;
        logic        mrv;
        logic [31:0] mrd;
    } stim_t;

    typedef struct {
        string name;
        logic  ifv;
        logic  kill;
        logic  dmv;
        logic  exp_if_rdy;
        logic  exp_dm_rdy;
    } arb_vec_t;

    int    total = 0;
    int    bad = 0;
    bit    grant_log[$];
    stim_t st;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well away from posedge.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        reset_i         = s.rst;
        if_req_v_i      = s.ifv;
        if_req_addr_i   = s.ifa;
        if_kill_i       = s.kill;
        dm_req_v_i      = s.dmv;
        dm_req_addr_i   = s.dma;
        dm_req_we_i     = s.we;
        dm_req_wmask_i  = s.wm;
        dm_req_wdata_i  = s.wd;
        mem_req_ready_i = s.mrdy;
        mem_resp_v_i    = s.mrv;
        mem_resp_data_i = s.mrd;
        #1;
    endtask

    task automatic resetDut();
        stim_t s;
        s = '{default: 0};
        s.rst = 1'b1;
        applyStimulus(s);
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    // Cycle-level reference: tracks one outstanding transaction, its owner and a starvation count.
    task automatic runModel(input int cycles, input int p_if, input int p_dm, input int p_kill,
                            input int p_rdy, input int p_resp);
        int          stage = 0;
        int          starve = 0;
        bit          own_dm = 0, killed = 0, pulse_if = 0, pulse_dm = 0, pulse_load = 0;
        logic [31:0] t_addr = 0, t_wdata = 0, pulse_data = 0;
        logic        t_we = 0;
        logic [3:0]  t_wmask = 0;
        bit          rif = 0, rdm = 0, rdm_we = 0;
        logic [31:0] rif_a = 0, rdm_a = 0, rdm_d = 0;
        logic [3:0]  rdm_m = 0;
        bit          elig, gdm, gif;
        stim_t       s;
        grant_log.delete();
        for (int cyc = 0; cyc < cycles; cyc++) begin
            if (!rif && $urandom_range(99) < p_if) begin
                rif   = 1;
                rif_a = $urandom & 32'hFFFF_FFFC;
            end
            if (!rdm && $urandom_range(99) < p_dm) begin
                rdm    = 1;
                rdm_a  = $urandom;
                rdm_we = 1'($urandom_range(1));
                rdm_m  = 4'($urandom);
                rdm_d  = $urandom;
            end
            s      = idleStim();
            s.ifv  = rif;
            s.ifa  = rif_a;
            s.kill = ($urandom_range(99) < p_kill);
            s.dmv  = rdm;
            s.dma  = rdm_a;
            s.we   = rdm_we;
            s.wm   = rdm_m;
            s.wd   = rdm_d;
            s.mrdy = ($urandom_range(99) < p_rdy);
            s.mrv  = (stage == 2) && ($urandom_range(99) < p_resp);
            s.mrd  = $urandom;
            applyStimulus(s);

            elig = rif && !s.kill;
            gdm  = (stage == 0) && rdm && !(elig && starve == LIMIT);
            gif  = (stage == 0) && !gdm && elig;
            checkOutput("rand_if_ready", if_req_ready_o, gif);
            checkOutput("rand_dm_ready", dm_req_ready_o, gdm);
            checkOutput("rand_busy", busy_o, stage != 0);
            checkOutput("rand_mem_v", mem_req_v_o, stage == 1);
            if (stage == 1) begin
                checkOutput("rand_mem_addr", mem_req_addr_o, t_addr);
                checkOutput("rand_mem_we", mem_req_we_o, t_we);
                if (own_dm) begin
                    checkOutput("rand_mem_wmask", mem_req_wmask_o, t_wmask);
                    checkOutput("rand_mem_wdata", mem_req_wdata_o, t_wdata);
                end
            end
            checkOutput("rand_if_resp_v", if_resp_v_o, pulse_if);
            checkOutput("rand_dm_resp_v", dm_resp_v_o, pulse_dm);
            if (pulse_if) checkOutput("rand_if_data", if_resp_data_o, pulse_data);
            if (pulse_dm && pulse_load) checkOutput("rand_dm_data", dm_resp_data_o, pulse_data);

            pulse_if   = (stage == 2) && s.mrv && !own_dm && !killed && !s.kill;
            pulse_dm   = (stage == 2) && s.mrv && own_dm;
            pulse_load = !t_we;
            pulse_data = s.mrd;
            if (stage != 0 && !own_dm && s.kill) killed = 1;
            if (stage == 2 && s.mrv) begin
                stage  = 0;
                killed = 0;
            end else if (stage == 1 && s.mrdy) begin
                stage = 2;
            end else if (gdm) begin
                stage   = 1;
                own_dm  = 1;
                t_addr  = rdm_a;
                t_we    = rdm_we;
                t_wmask = rdm_m;
                t_wdata = rdm_d;
                starve  = rif ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
                rdm     = 0;
                grant_log.push_back(1'b1);
            end else if (gif) begin
                stage  = 1;
                own_dm = 0;
                t_addr = rif_a;
                t_we   = 0;
                starve = 0;
                rif    = 0;
                grant_log.push_back(1'b0);
            end
            if (s.kill) rif = 0;
        end
    endtask

    initial begin
        arb_vec_t vecs[7];
        vecs[0] = '{"arb_none",      0, 0, 0, 0, 0};
        vecs[1] = '{"arb_if_only",   1, 0, 0, 1, 0};
        vecs[2] = '{"arb_if_killed", 1, 1, 0, 0, 0};
        vecs[3] = '{"arb_dm_only",   0, 0, 1, 0, 1};
        vecs[4] = '{"arb_both",      1, 0, 1, 0, 1};
        vecs[5] = '{"arb_both_kill", 1, 1, 1, 0, 1};
        vecs[6] = '{"arb_dm_kill",   0, 1, 1, 0, 1};

        st = idleStim();
        st.rst = 1'b1;
        applyStimulus(st);

        // Reset state
        applyStimulus(idleStim());
        checkOutput("rst_if_ready", if_req_ready_o, 0);
        checkOutput("rst_dm_ready", dm_req_ready_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_mem_v", mem_req_v_o, 0);
        checkOutput("rst_mem_addr", mem_req_addr_o, 0);
        checkOutput("rst_if_resp_v", if_resp_v_o, 0);
        checkOutput("rst_dm_resp_v", dm_resp_v_o, 0);
        checkOutput("rst_if_data", if_resp_data_o, 0);
        checkOutput("rst_dm_data", dm_resp_data_o, 0);

        // Arbitration table, each vector from a fresh IDLE with starve count zero
        for (int i = 0; i < 7; i++) begin
            resetDut();
            st = idleStim();
            st.ifv = vecs[i].ifv; st.ifa = 32'h40;
            st.kill = vecs[i].kill;
            st.dmv = vecs[i].dmv; st.dma = 32'h80;
            applyStimulus(st);
            checkOutput({vecs[i].name, "_if_rdy"}, if_req_ready_o, vecs[i].exp_if_rdy);
            checkOutput({vecs[i].name, "_dm_rdy"}, dm_req_ready_o, vecs[i].exp_dm_rdy);
            applyStimulus(idleStim());
            checkOutput({vecs[i].name, "_busy"}, busy_o, vecs[i].exp_if_rdy | vecs[i].exp_dm_rdy);
        end

        // Fetch-only latency: accept c0, mem ready c1, response c2, pulse c3
        resetDut();
        st = idleStim(); st.ifv = 1; st.ifa = 32'h100; applyStimulus(st);
        checkOutput("t1_if_ready", if_req_ready_o, 1);
        st = idleStim(); st.mrdy = 1; applyStimulus(st);
        checkOutput("t1_mem_v", mem_req_v_o, 1);
        checkOutput("t1_mem_addr", mem_req_addr_o, 32'h100);
        checkOutput("t1_mem_we", mem_req_we_o, 0);
        st = idleStim(); st.mrv = 1; st.mrd = 32'h13; applyStimulus(st);
        checkOutput("t1_mem_v_drop", mem_req_v_o, 0);
        checkOutput("t1_busy_resp", busy_o, 1);
        applyStimulus(idleStim());
        checkOutput("t1_if_resp_v", if_resp_v_o, 1);
        checkOutput("t1_if_data", if_resp_data_o, 32'h13);
        checkOutput("t1_busy_done", busy_o, 0);
        applyStimulus(idleStim());
        checkOutput("t1_if_resp_pulse", if_resp_v_o, 0);

        // Both valid: data wins, fetch accepted in the cycle the data response pulses
        resetDut();
        st = idleStim(); st.ifv = 1; st.ifa = 32'h104; st.dmv = 1; st.dma = 32'h200; applyStimulus(st);
        checkOutput("t2_dm_ready", dm_req_ready_o, 1);
        checkOutput("t2_if_ready", if_req_ready_o, 0);
        st = idleStim(); st.ifv = 1; st.ifa = 32'h104; st.mrdy = 1; applyStimulus(st);
        checkOutput("t2_mem_addr", mem_req_addr_o, 32'h200);
        checkOutput("t2_if_wait", if_req_ready_o, 0);
        st = idleStim(); st.ifv = 1; st.ifa = 32'h104; st.mrv = 1; st.mrd = 32'h55; applyStimulus(st);
        st = idleStim(); st.ifv = 1; st.ifa = 32'h104; applyStimulus(st);
        checkOutput("t2_dm_resp_v", dm_resp_v_o, 1);
        checkOutput("t2_dm_data", dm_resp_data_o, 32'h55);
        checkOutput("t2_if_ready_late", if_req_ready_o, 1);
        st = idleStim(); st.mrdy = 1; applyStimulus(st);
        checkOutput("t2_mem_addr_if", mem_req_addr_o, 32'h104);
        st = idleStim(); st.mrv = 1; st.mrd = 32'h77; applyStimulus(st);
        applyStimulus(idleStim());
        checkOutput("t2_if_resp_v", if_resp_v_o, 1);
        checkOutput("t2_if_data", if_resp_data_o, 32'h77);

        // Starvation: fetch and data both always valid, memory instant
        resetDut();
        runModel(40, 100, 100, 0, 100, 100);
        checkOutput("t3_grant_count", grant_log.size() >= 10, 1);
        for (int k = 0; k < 10 && k < grant_log.size(); k++) begin
            checkOutput($sformatf("t3_grant%0d_is_dm", k), grant_log[k], (k % 5) != 4);
        end

        // Kill during REQ: memory still completes, no fetch pulse, next data request proceeds
        resetDut();
        st = idleStim(); st.ifv = 1; st.ifa = 32'h300; applyStimulus(st);
        checkOutput("t4_if_ready", if_req_ready_o, 1);
        st = idleStim(); st.kill = 1; applyStimulus(st);
        checkOutput("t4_mem_v_kill", mem_req_v_o, 1);
        st = idleStim(); st.mrdy = 1; applyStimulus(st);
        checkOutput("t4_mem_v_held", mem_req_v_o, 1);
        checkOutput("t4_mem_addr", mem_req_addr_o, 32'h300);
        st = idleStim(); st.mrv = 1; st.mrd = 32'hBAD; applyStimulus(st);
        checkOutput("t4_busy_resp", busy_o, 1);
        st = idleStim(); st.dmv = 1; st.dma = 32'h600; applyStimulus(st);
        checkOutput("t4_if_resp_v", if_resp_v_o, 0);
        checkOutput("t4_busy_idle", busy_o, 0);
        checkOutput("t4_dm_ready", dm_req_ready_o, 1);
        st = idleStim(); st.mrdy = 1; applyStimulus(st);
        checkOutput("t4_mem_addr_dm", mem_req_addr_o, 32'h600);
        st = idleStim(); st.mrv = 1; st.mrd = 32'h66; applyStimulus(st);
        applyStimulus(idleStim());
        checkOutput("t4_dm_resp_v", dm_resp_v_o, 1);
        checkOutput("t4_dm_data", dm_resp_data_o, 32'h66);
        checkOutput("t4_if_resp_v2", if_resp_v_o, 0);

        // Store with memory stalled five cycles: request fields stay stable
        resetDut();
        st = idleStim(); st.dmv = 1; st.dma = 32'h400; st.we = 1; st.wm = 4'b0011; st.wd = 32'hDEADBEEF;
        applyStimulus(st);
        checkOutput("t5_dm_ready", dm_req_ready_o, 1);
        for (int k = 0; k < 6; k++) begin
            st = idleStim(); st.mrdy = (k == 5); applyStimulus(st);
            checkOutput($sformatf("t5_mem_v_%0d", k), mem_req_v_o, 1);
            checkOutput($sformatf("t5_mem_addr_%0d", k), mem_req_addr_o, 32'h400);
            checkOutput($sformatf("t5_mem_we_%0d", k), mem_req_we_o, 1);
            checkOutput($sformatf("t5_mem_wmask_%0d", k), mem_req_wmask_o, 4'b0011);
            checkOutput($sformatf("t5_mem_wdata_%0d", k), mem_req_wdata_o, 32'hDEADBEEF);
        end
        st = idleStim(); st.mrv = 1; applyStimulus(st);
        checkOutput("t5_dm_resp_early", dm_resp_v_o, 0);
        applyStimulus(idleStim());
        checkOutput("t5_dm_resp_v", dm_resp_v_o, 1);

        // Reset while waiting for a response, then a stray response arrives
        resetDut();
        st = idleStim(); st.ifv = 1; st.ifa = 32'h700; applyStimulus(st);
        st = idleStim(); st.mrdy = 1; applyStimulus(st);
        st = idleStim(); st.rst = 1; applyStimulus(st);
        st = idleStim(); st.mrv = 1; st.mrd = 32'hBAD; applyStimulus(st);
        checkOutput("t6_busy", busy_o, 0);
        checkOutput("t6_mem_v", mem_req_v_o, 0);
        checkOutput("t6_mem_addr", mem_req_addr_o, 0);
        applyStimulus(idleStim());
        checkOutput("t6_if_resp_v", if_resp_v_o, 0);
        checkOutput("t6_dm_resp_v", dm_resp_v_o, 0);
        checkOutput("t6_if_data", if_resp_data_o, 0);
        checkOutput("t6_busy_after", busy_o, 0);

        // Randomized traffic against the reference model
        resetDut();
        runModel(3000, 50, 50, 5, 50, 40);
        resetDut();
        runModel(3000, 90, 90, 10, 70, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
